// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec-configuration I2C command path:
// arbiter FSM states, codec bus addresses and default timing limits.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

    // Codec I2C device address and the fixed high byte of its register map
    localparam logic [7:0] CODEC_DEV_ADDR  = 8'b0111_0110;
    localparam logic [7:0] CODEC_SUBADDR_H = 8'h40;

    localparam logic [15:0] DEFAULT_TIMEOUT   = 16'd50000;
    localparam int unsigned DEFAULT_MAX_RETRY = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on contention the port that was not granted
// last wins. Purely combinational; the last_grant history lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares the codec I2C master between the init sequencer (port 0) and the
// runtime control path (port 1), with retry, watchdog and ack/err reporting.
module i2c_cmd_arbiter
    import codec_cfg_pkg::*;
#(
    parameter int unsigned     MAX_RETRY = DEFAULT_MAX_RETRY,
    parameter int unsigned     TO_W      = 16,
    parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(DEFAULT_TIMEOUT)
) (
    input  logic       audio_clk,
    input  logic       reset,
    input  logic       r0_req,
    input  logic [7:0] r0_subaddr,
    input  logic [7:0] r0_data,
    output logic       r0_ack,
    output logic       r0_err,
    input  logic       r1_req,
    input  logic [7:0] r1_subaddr,
    input  logic [7:0] r1_data,
    output logic       r1_ack,
    output logic       r1_err,
    output logic       m_write,
    output logic [7:0] m_subaddr,
    output logic [7:0] m_data,
    input  logic       m_ready,
    input  logic       m_error,
    output logic       busy,
    output logic [1:0] grant
);

    localparam logic [2:0]      RETRY_LIMIT = 3'(MAX_RETRY);
    localparam logic [TO_W-1:0] WDOG_LAST   = TIMEOUT - TO_W'(1);

    arb_state_t      state_q, state_d;
    logic [2:0]      retry_q, retry_d;
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            last_grant_q, last_grant_d;
    logic [1:0]      grant_q, grant_d;
    logic [7:0]      sub_q, sub_d;
    logic [7:0]      data_q, data_d;
    logic            write_q, write_d;
    logic [1:0]      ack_q, ack_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      arb_grant;
    logic            attempt_done;
    logic            attempt_fail;

    rr_arb2 u_arb (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (arb_grant)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        retry_d      = retry_q;
        wdog_d       = wdog_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        sub_d        = sub_q;
        data_d       = data_q;
        write_d      = 1'b0;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        attempt_done = 1'b0;
        attempt_fail = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_grant != 2'b00) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant[1];
                    retry_d      = '0;
                    sub_d        = arb_grant[1] ? r1_subaddr : r0_subaddr;
                    data_d       = arb_grant[1] ? r1_data    : r0_data;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    write_d = 1'b1;
                    wdog_d  = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (wdog_q == WDOG_LAST) begin
                    attempt_done = 1'b1;
                    attempt_fail = 1'b1;
                end else begin
                    wdog_d = wdog_q + TO_W'(1);
                    if (!m_ready) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Completion wins over a watchdog expiry in the same cycle
                if (m_ready) begin
                    attempt_done = 1'b1;
                    attempt_fail = m_error;
                end else if (wdog_q == WDOG_LAST) begin
                    attempt_done = 1'b1;
                    attempt_fail = 1'b1;
                end else begin
                    wdog_d = wdog_q + TO_W'(1);
                end
            end
            RESP: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The pulse is registered so it is visible during RESP, while grant is still held
        if (attempt_done) begin
            if (attempt_fail && (retry_q < RETRY_LIMIT)) begin
                retry_d = retry_q + 3'd1;
                state_d = ISSUE;
            end else begin
                ack_d   = attempt_fail ? 2'b00 : grant_q;
                err_d   = attempt_fail ? grant_q : 2'b00;
                state_d = RESP;
            end
        end
    end

    always_ff @(posedge audio_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            wdog_q       <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            sub_q        <= '0;
            data_q       <= '0;
            write_q      <= 1'b0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            wdog_q       <= wdog_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            sub_q        <= sub_d;
            data_q       <= data_d;
            write_q      <= write_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign m_write   = write_q;
    assign m_subaddr = sub_q;
    assign m_data    = data_q;
    assign r0_ack    = ack_q[0];
    assign r1_ack    = ack_q[1];
    assign r0_err    = err_q[0];
    assign r1_err    = err_q[1];

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: table of single transfers plus
// hand-written round-robin, timeout-with-pending and mid-transfer reset cases.
module tb_i2c_cmd_arbiter;

    typedef struct packed {
        logic [1:0] req;
        logic       drop;
        logic       stuck;
        logic [2:0] err_pat;
        logic [7:0] sub0;
        logic [7:0] dat0;
        logic [7:0] sub1;
        logic [7:0] dat1;
        logic [1:0] exp_grant;
        logic [3:0] exp_writes;
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        logic [7:0] exp_sub;
        logic [7:0] exp_dat;
    } vec_t;

    logic       audio_clk = 1'b0;
    logic       reset;
    logic       r0_req, r1_req;
    logic [7:0] r0_subaddr, r0_data, r1_subaddr, r1_data;
    logic       r0_ack, r0_err, r1_ack, r1_err;
    logic       m_write, m_ready, m_error, busy;
    logic [7:0] m_subaddr, m_data;
    logic [1:0] grant;

    i2c_cmd_arbiter #(.MAX_RETRY(2), .TO_W(16), .TIMEOUT(16'd100)) dut (
        .audio_clk  (audio_clk),
        .reset      (reset),
        .r0_req     (r0_req),
        .r0_subaddr (r0_subaddr),
        .r0_data    (r0_data),
        .r0_ack     (r0_ack),
        .r0_err     (r0_err),
        .r1_req     (r1_req),
        .r1_subaddr (r1_subaddr),
        .r1_data    (r1_data),
        .r1_ack     (r1_ack),
        .r1_err     (r1_err),
        .m_write    (m_write),
        .m_subaddr  (m_subaddr),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .m_error    (m_error),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 audio_clk = ~audio_clk;

    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         n_wr = 0, n_ack0 = 0, n_err0 = 0, n_ack1 = 0, n_err1 = 0, n_viol = 0;
    int         last_wr_cyc = 0;
    logic [7:0] cap_sub = 8'h00, cap_dat = 8'h00;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] grant_log[$];

    // Master model controls (written by the main sequence only)
    logic [2:0] mm_err_pat = 3'b000;
    bit         mm_stuck = 1'b0;
    int         err_base = 0;
    // Master model state (written by the model only)
    int         mm_writes = 0;

    vec_t vecs[6];

    // Master model: drops m_ready 3 cycles after m_write, restores it 20 cycles
    // later with the per-attempt error bit; stuck mode holds it low for 150.
    initial begin : master_model
        int phase, cnt, att;
        phase = 0; cnt = 0; att = 0;
        m_ready = 1'b1;
        m_error = 1'b0;
        forever begin
            @(posedge audio_clk);
            #2;
            if (!reset) begin
                phase = 0;
                m_ready = 1'b1;
                m_error = 1'b0;
            end else begin
                case (phase)
                    0: if (m_write) begin
                        att = mm_writes - err_base;
                        mm_writes++;
                        cnt = 0;
                        phase = 1;
                    end
                    1: begin
                        cnt++;
                        if (cnt == 3) begin
                            m_ready = 1'b0;
                            m_error = 1'b0;
                            cnt = 0;
                            phase = mm_stuck ? 3 : 2;
                        end
                    end
                    2: begin
                        cnt++;
                        if (cnt == 20) begin
                            m_ready = 1'b1;
                            m_error = (att >= 0 && att < 3) ? mm_err_pat[att] : 1'b0;
                            phase = 0;
                        end
                    end
                    default: begin
                        cnt++;
                        if (cnt == 150) begin
                            m_ready = 1'b1;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: got no summary by 1 ms, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample just after the edge and log events
    task automatic step();
        @(posedge audio_clk);
        #1;
        cyc++;
        if (m_write) begin
            n_wr++;
            last_wr_cyc = cyc;
            cap_sub = m_subaddr;
            cap_dat = m_data;
        end
        if (r0_ack) n_ack0++;
        if (r0_err) n_err0++;
        if (r1_ack) n_ack1++;
        if (r1_err) n_err1++;
        if (m_write && (r0_ack || r0_err || r1_ack || r1_err)) n_viol++;
        if ((32'(r0_ack) + 32'(r0_err) + 32'(r1_ack) + 32'(r1_err)) > 1) n_viol++;
        if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        r0_req = 1'b0;
        r1_req = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && !m_ready; i++) step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  w0, a0, e0, a1, e1, req_cyc, first_wr;
        bit  got;
        w0 = n_wr; a0 = n_ack0; e0 = n_err0; a1 = n_ack1; e1 = n_err1;
        first_wr = -1;
        mm_err_pat = v.err_pat;
        mm_stuck = v.stuck;
        err_base = mm_writes;
        r0_subaddr = v.sub0; r0_data = v.dat0;
        r1_subaddr = v.sub1; r1_data = v.dat1;
        r0_req = v.req[0];
        r1_req = v.req[1];
        req_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (grant != 2'b00) got = 1'b1;
        end
        check({tag, "_grant"}, 32'(grant), 32'(v.exp_grant));
        // Fields are latched at grant, so later input changes must not leak through
        r0_subaddr = ~v.sub0; r0_data = ~v.dat0;
        r1_subaddr = ~v.sub1; r1_data = ~v.dat1;
        if (v.drop) begin
            r0_req = 1'b0;
            r1_req = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            step();
            if (m_write && first_wr < 0) first_wr = cyc;
            if (r0_ack || r0_err || r1_ack || r1_err) got = 1'b1;
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_at_pulse"}, 32'(busy), 32'd1);
        r0_req = 1'b0;
        r1_req = 1'b0;
        step();
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_grant_after"}, 32'(grant), 32'd0);
        check({tag, "_writes"}, 32'(n_wr - w0), 32'(v.exp_writes));
        check({tag, "_acks"}, 32'((n_ack1 - a1) * 16 + (n_ack0 - a0)),
              32'(v.exp_ack[1]) * 16 + 32'(v.exp_ack[0]));
        check({tag, "_errs"}, 32'((n_err1 - e1) * 16 + (n_err0 - e0)),
              32'(v.exp_err[1]) * 16 + 32'(v.exp_err[0]));
        check({tag, "_m_subaddr"}, 32'(cap_sub), 32'(v.exp_sub));
        check({tag, "_m_data"}, 32'(cap_dat), 32'(v.exp_dat));
        check({tag, "_write_latency"}, 32'(first_wr - req_cyc), 32'd2);
        drain();
    endtask

    task automatic seq_round_robin();
        int  base, acks, a0, a1;
        bit  re0, re1;
        logic [1:0] g;
        do_reset();
        mm_err_pat = 3'b000;
        mm_stuck = 1'b0;
        err_base = mm_writes;
        base = grant_log.size();
        a0 = n_ack0; a1 = n_ack1;
        r0_subaddr = 8'h10; r0_data = 8'h11;
        r1_subaddr = 8'h20; r1_data = 8'h21;
        r0_req = 1'b1;
        r1_req = 1'b1;
        re0 = 1'b0; re1 = 1'b0; acks = 0;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            step();
            if (re0) begin r0_req = 1'b1; re0 = 1'b0; end
            if (re1) begin r1_req = 1'b1; re1 = 1'b0; end
            if (r0_ack) begin r0_req = 1'b0; re0 = 1'b1; acks++; end
            if (r1_ack) begin r1_req = 1'b0; re1 = 1'b1; acks++; end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        step();
        check("rr_acks", 32'(acks), 32'd4);
        check("rr_grant_count", 32'(grant_log.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            g = (base + k < grant_log.size()) ? grant_log[base + k] : 2'b00;
            check($sformatf("rr_grant%0d", k), 32'(g), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        check("rr_port_acks", 32'((n_ack1 - a1) * 16 + (n_ack0 - a0)), 32'h22);
        drain();
    endtask

    task automatic seq_timeout_pending();
        int  w0, a0, a1, e1;
        bit  got;
        do_reset();
        mm_err_pat = 3'b000;
        mm_stuck = 1'b1;
        err_base = mm_writes;
        w0 = n_wr; a0 = n_ack0; a1 = n_ack1; e1 = n_err1;
        r1_subaddr = 8'h5A; r1_data = 8'hA5;
        r1_req = 1'b1;
        step();
        step();
        check("to_grant_r1", 32'(grant), 32'h2);
        repeat (5) step();
        r0_subaddr = 8'h31; r0_data = 8'h13;
        r0_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            step();
            if (r1_err || r1_ack) got = 1'b1;
        end
        r1_req = 1'b0;
        mm_stuck = 1'b0;
        check("to_r1_err", 32'(r1_err), 32'd1);
        check("to_writes", 32'(n_wr - w0), 32'd3);
        check("to_attempt_cycles", 32'(cyc - last_wr_cyc), 32'd100);
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            step();
            if (r0_ack || r0_err) got = 1'b1;
        end
        r0_req = 1'b0;
        check("to_r0_ack", 32'(r0_ack), 32'd1);
        check("to_r0_grant", 32'(grant), 32'h1);
        check("to_r0_subaddr", 32'(cap_sub), 32'h31);
        check("to_r0_data", 32'(cap_dat), 32'h13);
        check("to_counts", 32'((n_ack1 - a1) * 256 + (n_err1 - e1) * 16 + (n_ack0 - a0)), 32'h011);
        step();
        drain();
    endtask

    task automatic seq_reset_mid();
        int  a0, e0, a1, e1;
        bit  got;
        vec_t fresh;
        do_reset();
        mm_err_pat = 3'b000;
        mm_stuck = 1'b0;
        err_base = mm_writes;
        a0 = n_ack0; e0 = n_err0; a1 = n_ack1; e1 = n_err1;
        r0_subaddr = 8'h66; r0_data = 8'h99;
        r0_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (m_write) got = 1'b1;
        end
        check("rm_write_seen", 32'(got), 32'd1);
        repeat (10) step();
        check("rm_in_transfer", 32'(busy), 32'd1);
        reset = 1'b0;
        r0_req = 1'b0;
        step();
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_grant", 32'(grant), 32'd0);
        check("rm_m_subaddr", 32'(m_subaddr), 32'd0);
        check("rm_m_data", 32'(m_data), 32'd0);
        check("rm_pulses", 32'({m_write, r0_ack, r0_err, r1_ack, r1_err}), 32'd0);
        reset = 1'b1;
        repeat (30) step();
        check("rm_no_pulse", 32'((n_ack0 - a0) + (n_err0 - e0) + (n_ack1 - a1) + (n_err1 - e1)), 32'd0);
        fresh = '{req: 2'b01, drop: 1'b0, stuck: 1'b0, err_pat: 3'b000,
                  sub0: 8'h77, dat0: 8'h88, sub1: 8'h00, dat1: 8'h00,
                  exp_grant: 2'b01, exp_writes: 4'd1, exp_ack: 2'b01, exp_err: 2'b00,
                  exp_sub: 8'h77, exp_dat: 8'h88};
        run_vec(fresh, "rm_fresh");
    endtask

    initial begin : main
        reset = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_subaddr = 8'h00; r0_data = 8'h00;
        r1_subaddr = 8'h00; r1_data = 8'h00;

        vecs[0] = '{req: 2'b01, drop: 1'b0, stuck: 1'b0, err_pat: 3'b000,
                    sub0: 8'h15, dat0: 8'h01, sub1: 8'hEE, dat1: 8'hEE,
                    exp_grant: 2'b01, exp_writes: 4'd1, exp_ack: 2'b01, exp_err: 2'b00,
                    exp_sub: 8'h15, exp_dat: 8'h01};
        vecs[1] = '{req: 2'b10, drop: 1'b0, stuck: 1'b0, err_pat: 3'b011,
                    sub0: 8'hEE, dat0: 8'hEE, sub1: 8'hA3, dat1: 8'h5C,
                    exp_grant: 2'b10, exp_writes: 4'd3, exp_ack: 2'b10, exp_err: 2'b00,
                    exp_sub: 8'hA3, exp_dat: 8'h5C};
        vecs[2] = '{req: 2'b01, drop: 1'b0, stuck: 1'b0, err_pat: 3'b111,
                    sub0: 8'h7F, dat0: 8'h80, sub1: 8'hEE, dat1: 8'hEE,
                    exp_grant: 2'b01, exp_writes: 4'd3, exp_ack: 2'b00, exp_err: 2'b01,
                    exp_sub: 8'h7F, exp_dat: 8'h80};
        vecs[3] = '{req: 2'b10, drop: 1'b1, stuck: 1'b0, err_pat: 3'b000,
                    sub0: 8'hEE, dat0: 8'hEE, sub1: 8'h00, dat1: 8'hFF,
                    exp_grant: 2'b10, exp_writes: 4'd1, exp_ack: 2'b10, exp_err: 2'b00,
                    exp_sub: 8'h00, exp_dat: 8'hFF};
        vecs[4] = '{req: 2'b10, drop: 1'b0, stuck: 1'b1, err_pat: 3'b000,
                    sub0: 8'hEE, dat0: 8'hEE, sub1: 8'h22, dat1: 8'h33,
                    exp_grant: 2'b10, exp_writes: 4'd3, exp_ack: 2'b00, exp_err: 2'b10,
                    exp_sub: 8'h22, exp_dat: 8'h33};
        vecs[5] = '{req: 2'b01, drop: 1'b0, stuck: 1'b0, err_pat: 3'b001,
                    sub0: 8'h4C, dat0: 8'hD2, sub1: 8'hEE, dat1: 8'hEE,
                    exp_grant: 2'b01, exp_writes: 4'd2, exp_ack: 2'b01, exp_err: 2'b00,
                    exp_sub: 8'h4C, exp_dat: 8'hD2};

        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_m_subaddr", 32'(m_subaddr), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_pulses", 32'({m_write, r0_ack, r0_err, r1_ack, r1_err}), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        seq_round_robin();
        seq_timeout_pending();
        seq_reset_mid();

        check("protocol_violations", 32'(n_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
